// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder types and constants.
package ldpc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    CHECK,
    VN_WAIT,
    DONE
  } sched_state_t;

  localparam int CNU_PIPE_LAT   = 2;
  localparam int DEF_NUM_CHECKS = 8;
  localparam int DEF_MAX_ITER   = 10;

endpackage

// File: rtl/cnu_scheduler_if.sv
// Control and datapath signals between the CNU scheduler and its neighbours.
interface cnu_scheduler_if #(
  parameter int ROW_W  = 3,
  parameter int ITER_W = 4
);
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              success;
  logic [ITER_W-1:0] iter_count;
  logic              rd_en;
  logic [ROW_W-1:0]  rd_addr;
  logic              cnu_en;
  logic              wr_en;
  logic [ROW_W-1:0]  wr_addr;
  logic              p_bit;
  logic              vn_start;
  logic              vn_done;

  modport master (
    input  start, abort, p_bit, vn_done,
    output busy, done, success, iter_count, rd_en, rd_addr,
           cnu_en, wr_en, wr_addr, vn_start
  );

  modport slave (
    output start, abort, p_bit, vn_done,
    input  busy, done, success, iter_count, rd_en, rd_addr,
           cnu_en, wr_en, wr_addr, vn_start
  );
endinterface

// File: rtl/cnu_issue_pipe.sv
// Valid/address shift register tracking rows from RAM read through CNU to write-back.
module cnu_issue_pipe
  import ldpc_pkg::*;
#(
  parameter int ROW_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             rd_en,
  input  logic [ROW_W-1:0] rd_addr,
  output logic             cnu_en,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_addr
);

  logic [CNU_PIPE_LAT:1]            vld_pipe;
  logic [CNU_PIPE_LAT:1][ROW_W-1:0] addr_pipe;

  // Addresses only advance with a valid row so wr_addr holds between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[CNU_PIPE_LAT-1:1], rd_en};
      if (rd_en) addr_pipe[1] <= rd_addr;
      for (int i = 2; i <= CNU_PIPE_LAT; i++)
        if (vld_pipe[i-1]) addr_pipe[i] <= addr_pipe[i-1];
    end
  end

  assign cnu_en  = vld_pipe[1];
  assign wr_en   = vld_pipe[CNU_PIPE_LAT];
  assign wr_addr = addr_pipe[CNU_PIPE_LAT];

endmodule

// File: rtl/cnu_scheduler.sv
// Sequences one CNU over all check rows per phase, alternating with PE phases until
// the syndrome clears or the iteration limit is hit.
module cnu_scheduler
  import ldpc_pkg::*;
#(
  parameter int NUM_CHECKS = DEF_NUM_CHECKS,
  parameter int ROW_W      = $clog2(NUM_CHECKS),
  parameter int MAX_ITER   = DEF_MAX_ITER,
  parameter int ITER_W     = 4
) (
  input logic             clk,
  input logic             rst_n,
  cnu_scheduler_if.master bus
);

  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(NUM_CHECKS - 1);
  localparam logic [ITER_W-1:0] MAX_I    = ITER_W'(MAX_ITER);

  sched_state_t      state, state_nxt;
  logic [ROW_W-1:0]  rd_addr;
  logic [ITER_W-1:0] iter_count, iter_inc;
  logic              success, syndrome_nz, limit_hit;

  assign iter_inc  = (iter_count == MAX_I) ? iter_count : iter_count + 1'b1;
  assign limit_hit = (iter_inc == MAX_I);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ISSUE;
      ISSUE:   if (rd_addr == LAST_ROW) state_nxt = DRAIN;
      // Stage 1 empty means the final write-back lands this cycle, so CHECK
      // sees the fully folded syndrome.
      DRAIN:   if (!bus.cnu_en) state_nxt = CHECK;
      CHECK:   state_nxt = (!syndrome_nz || limit_hit) ? DONE : VN_WAIT;
      VN_WAIT: if (bus.vn_done) state_nxt = ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_addr     <= '0;
      iter_count  <= '0;
      success     <= 1'b0;
      syndrome_nz <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus.abort && state != IDLE) begin
        success <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            iter_count  <= '0;
            syndrome_nz <= 1'b0;
            success     <= 1'b0;
            rd_addr     <= '0;
          end
          ISSUE:   if (rd_addr != LAST_ROW) rd_addr <= rd_addr + 1'b1;
          CHECK: begin
            iter_count <= iter_inc;
            success    <= !syndrome_nz;
            if (syndrome_nz && !limit_hit) syndrome_nz <= 1'b0;
          end
          VN_WAIT: if (bus.vn_done) rd_addr <= '0;
          default: ;
        endcase
        if (bus.wr_en && bus.p_bit) syndrome_nz <= 1'b1;
      end
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.rd_en      = (state == ISSUE);
  assign bus.rd_addr    = rd_addr;
  assign bus.success    = success;
  assign bus.iter_count = iter_count;
  assign bus.vn_start   = (state == CHECK) && syndrome_nz && !limit_hit && !bus.abort;

  cnu_issue_pipe #(.ROW_W(ROW_W)) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (bus.abort),
    .rd_en   (bus.rd_en),
    .rd_addr (rd_addr),
    .cnu_en  (bus.cnu_en),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr)
  );

endmodule

// File: tb/tb_cnu_scheduler.sv
// Bench for cnu_scheduler: per-cycle schedule model, table vectors, random decodes,
// reset and abort sequences.
module tb_cnu_scheduler;
  localparam int N   = 4;
  localparam int MAX = 3;
  localparam int RW  = 2;
  localparam int IW  = 4;
  localparam int L   = 128;

  logic clk, rst_n;
  int   tests, fails;

  cnu_scheduler_if #(.ROW_W(RW), .ITER_W(IW)) bus ();

  cnu_scheduler #(.NUM_CHECKS(N), .ROW_W(RW), .MAX_ITER(MAX), .ITER_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected per-cycle schedule, indexed by cycles since the start cycle.
  bit          m_rd[L], m_cnu[L], m_wr[L], m_vn[L], m_busy[L], m_done[L], m_p[L], m_vnd[L];
  logic [RW-1:0] m_rda[L], m_wra[L];
  int          m_done_cyc, m_iter;
  bit          m_succ;

  typedef struct {
    logic [11:0] pat;   // bit k*N+r: parity of row r in phase k
    int          d;     // vn_done delay after vn_start
    bit          noise;
    bit          succ;
    int          iter;
    int          nvn;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic build_model(input logic [11:0] pat, input int d);
    int  t, c;
    bit  syn;
    for (int i = 0; i < L; i++) begin
      m_rd[i] = 0; m_cnu[i] = 0; m_wr[i] = 0; m_vn[i] = 0;
      m_busy[i] = 0; m_done[i] = 0; m_p[i] = 0; m_vnd[i] = 0;
      m_rda[i] = '0; m_wra[i] = '0;
    end
    t = 1;
    m_done_cyc = 0; m_iter = 0; m_succ = 0;
    for (int k = 0; k < MAX; k++) begin
      syn = 0;
      for (int r = 0; r < N; r++) begin
        m_rd[t+r]    = 1;  m_rda[t+r]   = RW'(r);
        m_cnu[t+r+1] = 1;
        m_wr[t+r+2]  = 1;  m_wra[t+r+2] = RW'(r);
        m_p[t+r+2]   = pat[k*N+r];
        syn          = syn | pat[k*N+r];
      end
      c      = t + N + 2;
      m_iter = k + 1;
      if (!syn || m_iter == MAX) begin
        m_done_cyc = c + 1;
        m_succ     = !syn;
        break;
      end
      m_vn[c]    = 1;
      m_vnd[c+d] = 1;
      t          = c + d + 1;
    end
    for (int i = 1; i <= m_done_cyc; i++) m_busy[i] = 1;
    m_done[m_done_cyc] = 1;
  endtask

  function automatic logic [31:0] act_vec();
    return {22'd0, bus.busy, bus.done, bus.rd_en, bus.cnu_en, bus.wr_en, bus.vn_start,
            (bus.rd_en ? bus.rd_addr : RW'(0)), (bus.wr_en ? bus.wr_addr : RW'(0))};
  endfunction

  function automatic logic [31:0] exp_vec(input int c);
    return {22'd0, m_busy[c], m_done[c], m_rd[c], m_cnu[c], m_wr[c], m_vn[c],
            (m_rd[c] ? m_rda[c] : RW'(0)), (m_wr[c] ? m_wra[c] : RW'(0))};
  endfunction

  function automatic logic [31:0] all_vec();
    return {17'd0, bus.busy, bus.done, bus.success, bus.iter_count, bus.rd_en, bus.rd_addr,
            bus.cnu_en, bus.wr_en, bus.wr_addr, bus.vn_start};
  endfunction

  task automatic run_decode(input logic [11:0] pat, input int d, input bit noise,
                            output bit succ_o, output int iter_o, output int nvn_o);
    build_model(pat, d);
    nvn_o  = 0;
    succ_o = 0;
    iter_o = -1;
    if (noise) begin
      @(posedge clk); #1;
      bus.vn_done = 1'b1;
      @(negedge clk);
      chk("idle_vn_done", 32'(bus.busy), 32'd0);
    end
    for (int cyc = 0; cyc <= m_done_cyc + 3; cyc++) begin
      @(posedge clk); #1;
      bus.start   = (cyc == 0) || (noise && (cyc == 2 || cyc == m_done_cyc));
      bus.vn_done = m_vnd[cyc] || (noise && cyc == 3);
      bus.p_bit   = m_wr[cyc] ? m_p[cyc] : 1'($urandom);
      @(negedge clk);
      chk("sched", act_vec(), exp_vec(cyc));
      if (bus.vn_start) nvn_o++;
      if (cyc >= m_done_cyc) begin
        chk("success", 32'(bus.success), 32'(m_succ));
        chk("iter_count", 32'(bus.iter_count), 32'(m_iter));
      end
      if (cyc == m_done_cyc) begin
        succ_o = bus.success;
        iter_o = int'(bus.iter_count);
      end
    end
    bus.start   = 1'b0;
    bus.vn_done = 1'b0;
    bus.p_bit   = 1'b0;
  endtask

  initial begin
    bit succ;
    int iter, nvn;
    tests = 0;
    fails = 0;
    tbl[0] = '{12'h000, 3, 1'b0, 1'b1, 1, 0};  // clean decode
    tbl[1] = '{12'h444, 3, 1'b0, 1'b0, 3, 2};  // row 2 fails every phase
    tbl[2] = '{12'h001, 3, 1'b0, 1'b1, 2, 1};  // converge on second phase
    tbl[3] = '{12'h000, 3, 1'b1, 1'b1, 1, 0};  // ignored start/vn_done
    tbl[4] = '{12'h444, 2, 1'b1, 1'b0, 3, 2};
    tbl[5] = '{12'h018, 1, 1'b0, 1'b1, 3, 2};  // converge on the final allowed phase

    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.p_bit = 1'b0; bus.vn_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", all_vec(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_decode(tbl[i].pat, tbl[i].d, tbl[i].noise, succ, iter, nvn);
      chk("tbl_success", 32'(succ), 32'(tbl[i].succ));
      chk("tbl_iter", 32'(iter), 32'(tbl[i].iter));
      chk("tbl_vn_starts", 32'(nvn), 32'(tbl[i].nvn));
    end

    // Reset mid-ISSUE with rows in flight.
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_issue", all_vec(), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_wr", all_vec(), 32'd0);
    end

    // Abort in the cycle row 1 is read.
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_rd_addr", 32'(bus.rd_addr), 32'd1);
    @(posedge clk); #1 bus.abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_quiet", {25'd0, bus.busy, bus.done, bus.rd_en, bus.cnu_en, bus.wr_en,
                          bus.vn_start, bus.success}, 32'd0);
      chk("abort_iter", 32'(bus.iter_count), 32'd0);
      @(posedge clk); #1;
    end
    run_decode(12'h000, 3, 1'b0, succ, iter, nvn);
    chk("abort_rerun", {30'd0, succ, 1'b0} | 32'(iter), 32'd3);

    // Random decodes against the schedule model.
    for (int i = 0; i < 20; i++) begin
      run_decode(12'($urandom & $urandom), int'($urandom_range(1, 5)), 1'($urandom),
                 succ, iter, nvn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
